// File: rtl/rx_word.sv
// rx_word: 8N1 UART receiver that pairs bytes into 16-bit words, low byte first.
// Optional macro RX_TIMEOUT_EN discards a stale low byte after TIMEOUT_BITS idle bit periods.
module rx_word #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk100M,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_params
    $error("rx_word: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    low_q, low_d;
  logic          phase_hi_q, phase_hi_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          byte_ok, word_done;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);
  logic [CW-1:0] tmo_clk_q, tmo_clk_d;
  logic [TW-1:0] tmo_bits_q, tmo_bits_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  // State register and all datapath flops
  always_ff @(posedge clk100M) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      low_q        <= '0;
      phase_hi_q   <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_clk_q     <= '0;
      tmo_bits_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      low_q        <= low_d;
      phase_hi_q   <= phase_hi_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef RX_TIMEOUT_EN
      tmo_clk_q     <= tmo_clk_d;
      tmo_bits_q    <= tmo_bits_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state, byte pairing and output handshake
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    low_d        = low_q;
    phase_hi_d   = phase_hi_q;
    rx_meta_d    = uart_rx;
    rx_sync_d    = rx_meta_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    byte_ok      = 1'b0;
    word_done    = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo_clk_d     = tmo_clk_q;
    tmo_bits_d    = tmo_bits_q;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // Return to IDLE mid stop bit so a back-to-back start edge is never missed
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (rx_sync_q) begin
            byte_ok = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            phase_hi_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_ok) begin
      if (!phase_hi_q) begin
        low_d      = shift_q;
        phase_hi_d = 1'b1;
      end else begin
        word_done  = 1'b1;
        phase_hi_d = 1'b0;
      end
    end

    if (data_valid_q && data_ready) data_valid_d = 1'b0;
    if (word_done) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = {shift_q, low_q};
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

`ifdef RX_TIMEOUT_EN
    // Count idle bit periods only while a low byte waits for its partner
    if (state_q != S_IDLE || !phase_hi_q || !rx_sync_q) begin
      tmo_clk_d  = '0;
      tmo_bits_d = '0;
    end else if (tmo_clk_q == FULL_M1) begin
      tmo_clk_d = '0;
      if (tmo_bits_q == TW'(TIMEOUT_BITS - 1)) begin
        tmo_bits_d    = '0;
        phase_hi_d    = 1'b0;
        timeout_err_d = 1'b1;
      end else begin
        tmo_bits_d = tmo_bits_q + TW'(1);
      end
    end else begin
      tmo_clk_d = tmo_clk_q + CW'(1);
    end
`endif
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef RX_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
